systolic_tile_sequencer: RTL and testbench
==========================================

# systolic_tile_sequencer

Sequences K-deep operand streams into a ROWS×COLS output-stationary array of `single_PE` cells.
- Issues linear read addresses to the A (row) and B (column) operand buffers.
- Generates the diagonal `finish` wavefront that closes one tile and starts the next.
- Injects a zero flush beat so the last tile's results latch.
- Flags when each anti-diagonal of PEs holds a fresh `o_result`.
- Sits between the host command interface and the array's edge skew registers.

## Interface
- ROWS, 4, array rows
- COLS, 4, array columns
- K_WIDTH, 8, width of `k_len`
- T_WIDTH, 8, width of `n_tiles`
- ADDR_WIDTH, 8, operand buffer address width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  command strobe; accepted only when `ready`=1
- k_len  in  K_WIDTH  beats per tile; sampled with `start`
- n_tiles  in  T_WIDTH  tiles per command; sampled with `start`
- a_base, b_base  in  ADDR_WIDTH each  first read address, A and B; sampled with `start`
- ready  out  1  idle, can accept `start`
- a_rd_en, b_rd_en  out  1 each  buffer read enables
- a_rd_addr, b_rd_addr  out  ADDR_WIDTH each  buffer read addresses
- feed_zero  out  1  force array-edge operands to 0 this cycle
- finish_diag  out  ROWS+COLS-1  bit d drives `finish` of every PE(i,j) with i+j=d
- result_valid_diag  out  ROWS+COLS-1  bit d: PEs on diagonal d present a new tile result
- done  out  1  one-cycle pulse: command complete

## Operation
- Definitions:
  - N = n_tiles·k_len
  - D = ROWS+COLS-2
  - Buffer read latency is 1: the address issued in cycle c is presented at the array edge in cycle c+1.
  - The external skew delays row i by i cycles and column j by j cycles, so the beat presented in cycle c+1 reaches PE(i,j) in cycle c+1+i+j.
- FSM states: IDLE → STREAM → FLUSH → DRAIN → IDLE.
- IDLE:
  - `ready`=1.
  - `start` latches k_len, n_tiles, a_base and b_base.
  - If k_len=0 or n_tiles=0, the command completes with no reads and no finish.
- STREAM:
  - Lasts N cycles.
  - `a_rd_en`=`b_rd_en`=1.
  - Addresses are base+beat for beat=0..N-1, wrapping modulo 2^ADDR_WIDTH.
  - A beat counter (0..k_len-1) and a tile counter (0..n_tiles-1) advance.
- FLUSH:
  - Lasts 1 cycle.
  - Read enables are 0 and addresses hold their last value.
  - The zero beat reaches the edge in the following cycle, with `feed_zero`=1 in that cycle only.
- DRAIN:
  - Waits until the finish/result shift registers are empty.
  - Asserts `done` for one cycle, then returns to IDLE.
- Finish wavefront:
  - `finish_diag[0]` is 1 in the presentation cycle of beat 0 of every tile and of the flush beat.
  - `finish_diag[d]` is `finish_diag[0]` delayed by d cycles (shift register).
- Result flags:
  - `result_valid_diag[d]` is `finish_diag[d]` delayed by 1 cycle.
  - The wave produced by the first tile's beat 0 is masked, since no prior result exists.
- Arithmetic: counters compare against the latched k_len and n_tiles. N is never formed as a product; the tile counter terminates the stream.
- `start` while `ready`=0 is ignored and has no effect.
- Reset, asynchronous and valid at any time, including mid-STREAM:
  - `ready`=1; `done`=0.
  - Read enables = 0; addresses = 0.
  - `feed_zero`=0; all finish and result shift registers cleared.
  - FSM goes to IDLE.

## Timing
- Cycle 0: `start` sampled with `ready`=1.
- Cycles 1..N: reads issued.
- Cycle N+1: FLUSH.
- Cycle N+2: `feed_zero`=1 and `finish_diag[0]`=1 (flush wave).
- Tile t, beat 0: `finish_diag[0]` in cycle 2+t·k_len.
- Last flag: `result_valid_diag[D]` in cycle N+D+3.
- Cycle N+D+4: `done`=1 and `ready`=1; a new `start` is accepted in this cycle.
- Degenerate command (k_len=0 or n_tiles=0): `done`=1 and `ready`=1 in cycle 1.
- k_len=1: `finish_diag[0]` is high in every cycle 2..N+2.
- Latency from `start` to `done`: N+D+4 cycles.

## Test plan
- ROWS=COLS=4, k_len=3, n_tiles=1, a_base=0x10, start@0:
  - `a_rd_addr` = 0x10, 0x11, 0x12 in cycles 1–3.
  - `finish_diag[0]` high in cycles 2 and 5.
  - `feed_zero` high in cycle 5.
  - `result_valid_diag[0]` high in cycle 6; `result_valid_diag[6]` high in cycle 12.
  - `done` high in cycle 13.
- k_len=2, n_tiles=2:
  - `finish_diag[0]` high in cycles 2, 4, 6.
  - `result_valid_diag[0]` high in cycles 5 and 7 only.
  - `done` high in cycle 14.
- k_len=1, n_tiles=3: `finish_diag[0]` high in cycles 2–5; `finish_diag[3]` high in cycles 5–8.
- a_base=0xFE, k_len=4, n_tiles=1, ADDR_WIDTH=8: `a_rd_addr` = 0xFE, 0xFF, 0x00, 0x01.
- k_len=0:
  - No read enables and no finish.
  - `done`=1 in cycle 1.
  - `start` pulsed again in cycle 3 while busy on a valid command is ignored.
- Assert `rst_n`=0 in cycle 3 of a k_len=8 command:
  - All outputs are at reset values immediately.
  - After release, a new command starting from a_base=0 behaves as in the first scenario.

Source files
------------

// File: rtl/systolic_tile_sequencer.sv
// systolic_tile_sequencer
// Streams K-deep operand reads into an output-stationary systolic array,
// launches the diagonal finish wavefront that closes each tile, injects a
// zero flush beat after the last tile, and flags fresh results per diagonal.
module systolic_tile_sequencer #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int K_WIDTH    = 8,
    parameter int T_WIDTH    = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [K_WIDTH-1:0]       k_len,
    input  logic [T_WIDTH-1:0]       n_tiles,
    input  logic [ADDR_WIDTH-1:0]    a_base,
    input  logic [ADDR_WIDTH-1:0]    b_base,
    output logic                     ready,
    output logic                     a_rd_en,
    output logic                     b_rd_en,
    output logic [ADDR_WIDTH-1:0]    a_rd_addr,
    output logic [ADDR_WIDTH-1:0]    b_rd_addr,
    output logic                     feed_zero,
    output logic [ROWS+COLS-2:0]     finish_diag,
    output logic [ROWS+COLS-2:0]     result_valid_diag,
    output logic                     done
);

    localparam int DIAGS = ROWS + COLS - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [K_WIDTH-1:0]    k_lat;
    logic [T_WIDTH-1:0]    n_lat;
    logic [K_WIDTH-1:0]    beat_cnt;
    logic [T_WIDTH-1:0]    tile_cnt;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DIAGS-1:0]      fin_sr;
    logic [DIAGS-1:0]      res_sr;
    logic [DIAGS-1:0]      rv_q;
    logic                  feed_q;
    logic                  done_q;

    logic                  rd_en;
    logic                  cmd_load;
    logic                  inject_fin;
    logic                  inject_res;
    logic                  done_set;
    logic                  beat_last;
    logic                  stream_last;

    // The beat counter wraps at the latched tile depth; the stream ends on
    // the last beat of the last tile, so N is never formed as a product.
    assign beat_last   = (beat_cnt == k_lat - K_WIDTH'(1));
    assign stream_last = beat_last && (tile_cnt == n_lat - T_WIDTH'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        rd_en      = 1'b0;
        cmd_load   = 1'b0;
        inject_fin = 1'b0;
        inject_res = 1'b0;
        done_set   = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    if ((k_len == '0) || (n_tiles == '0)) begin
                        done_set = 1'b1;
                    end else begin
                        cmd_load   = 1'b1;
                        state_next = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                rd_en      = 1'b1;
                inject_fin = (beat_cnt == '0);
                inject_res = (beat_cnt == '0) && (tile_cnt != '0);
                if (stream_last) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                inject_fin = 1'b1;
                inject_res = 1'b1;
                state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if ((fin_sr == '0) && (res_sr == '0)) begin
                    done_set   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Command latch, beat/tile counters and linear read addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_lat    <= '0;
            n_lat    <= '0;
            beat_cnt <= '0;
            tile_cnt <= '0;
            a_addr   <= '0;
            b_addr   <= '0;
        end else if (cmd_load) begin
            k_lat    <= k_len;
            n_lat    <= n_tiles;
            beat_cnt <= '0;
            tile_cnt <= '0;
            a_addr   <= a_base;
            b_addr   <= b_base;
        end else if ((state == S_STREAM) && !stream_last) begin
            a_addr <= a_addr + ADDR_WIDTH'(1);
            b_addr <= b_addr + ADDR_WIDTH'(1);
            if (beat_last) begin
                beat_cnt <= '0;
                tile_cnt <= tile_cnt + T_WIDTH'(1);
            end else begin
                beat_cnt <= beat_cnt + K_WIDTH'(1);
            end
        end
    end

    // Finish and result wavefronts, flush marker and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_sr <= '0;
            res_sr <= '0;
            rv_q   <= '0;
            feed_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            fin_sr <= {fin_sr[DIAGS-2:0], inject_fin};
            res_sr <= {res_sr[DIAGS-2:0], inject_res};
            rv_q   <= res_sr;
            feed_q <= (state == S_FLUSH);
            done_q <= done_set;
        end
    end

    assign a_rd_en           = rd_en;
    assign b_rd_en           = rd_en;
    assign a_rd_addr         = a_addr;
    assign b_rd_addr         = b_addr;
    assign feed_zero         = feed_q;
    assign finish_diag       = fin_sr;
    assign result_valid_diag = rv_q;
    assign done              = done_q;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer: a cycle-indexed reference model derived
// from the command timing rules, compared every cycle, plus directed literals.
module tb_systolic_tile_sequencer;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DG   = ROWS + COLS - 1;
    localparam int D    = ROWS + COLS - 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    k_len;
    logic [7:0]    n_tiles;
    logic [7:0]    a_base;
    logic [7:0]    b_base;
    logic          ready;
    logic          a_rd_en;
    logic          b_rd_en;
    logic [7:0]    a_rd_addr;
    logic [7:0]    b_rd_addr;
    logic          feed_zero;
    logic [DG-1:0] finish_diag;
    logic [DG-1:0] result_valid_diag;
    logic          done;

    systolic_tile_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .K_WIDTH(8), .T_WIDTH(8), .ADDR_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .n_tiles(n_tiles), .a_base(a_base), .b_base(b_base), .ready(ready),
        .a_rd_en(a_rd_en), .b_rd_en(b_rd_en), .a_rd_addr(a_rd_addr),
        .b_rd_addr(b_rd_addr), .feed_zero(feed_zero),
        .finish_diag(finish_diag), .result_valid_diag(result_valid_diag),
        .done(done)
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatch = 0;
    int cyc = 0;
    int cmd0 = 0;

    // Reference model: the most recently accepted command and its start cycle.
    bit has_cmd = 0;
    bit m_deg = 0;
    int m_s = 0, m_k = 0, m_n = 0, m_N = 0, m_L = 0, m_a = 0, m_b = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Edge presentation of a finish beat at command-relative cycle x.
    function automatic bit fin0_at(input int x);
        if (!has_cmd || m_deg || x < 2 || x > m_N + 2) return 1'b0;
        return ((x - 2) % m_k) == 0;
    endfunction

    function automatic bit exp_ready_now();
        int rel;
        if (!has_cmd) return 1'b1;
        rel = cyc - m_s;
        return !(rel >= 1 && rel <= m_L - 1);
    endfunction

    // Model update on each sampling edge, then advance the cycle index.
    always @(posedge clk) begin
        if (!rst_n) begin
            has_cmd = 0;
        end else if (start === 1'b1 && exp_ready_now()) begin
            has_cmd = 1;
            m_s = cyc;
            m_k = int'(k_len);
            m_n = int'(n_tiles);
            m_a = int'(a_base);
            m_b = int'(b_base);
            m_N = m_k * m_n;
            m_deg = (m_N == 0);
            m_L = m_deg ? 1 : m_N + D + 4;
        end
        cyc = cyc + 1;
    end

    int            c_rel, c_off;
    logic [DG-1:0] e_fin, e_rv;
    bit            e_ready, e_rd, e_fz, e_done, e_chk_addr;
    logic [7:0]    e_a, e_b;

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        c_rel = cyc - m_s;
        e_fin = '0; e_rv = '0; e_ready = 1; e_rd = 0; e_fz = 0; e_done = 0;
        e_chk_addr = 0; e_a = '0; e_b = '0;
        if (!rst_n) begin
            e_chk_addr = 1;
        end else if (has_cmd) begin
            for (int d = 0; d < DG; d++) begin
                e_fin[d] = fin0_at(c_rel - d);
                e_rv[d]  = fin0_at(c_rel - d - 1) && (c_rel - d - 1 != 2);
            end
            e_ready = exp_ready_now();
            e_done  = (c_rel == m_L);
            if (!m_deg) begin
                e_rd = (c_rel >= 1 && c_rel <= m_N);
                e_fz = (c_rel == m_N + 2);
                if (c_rel >= 1 && c_rel <= m_N + 1) begin
                    e_chk_addr = 1;
                    c_off = (c_rel <= m_N) ? c_rel - 1 : m_N - 1;
                    e_a = 8'(m_a + c_off);
                    e_b = 8'(m_b + c_off);
                end
            end
        end
        checkOutput("ready", 32'(ready), 32'(e_ready));
        checkOutput("a_rd_en", 32'(a_rd_en), 32'(e_rd));
        checkOutput("b_rd_en", 32'(b_rd_en), 32'(e_rd));
        checkOutput("feed_zero", 32'(feed_zero), 32'(e_fz));
        checkOutput("finish_diag", 32'(finish_diag), 32'(e_fin));
        checkOutput("result_valid_diag", 32'(result_valid_diag), 32'(e_rv));
        checkOutput("done", 32'(done), 32'(e_done));
        if (e_chk_addr) begin
            checkOutput("a_rd_addr", 32'(a_rd_addr), 32'(e_a));
            checkOutput("b_rd_addr", 32'(b_rd_addr), 32'(e_b));
        end
    end

    // Drive one start strobe from the current point, sampled at the next edge.
    task automatic applyStimulus(input int k, input int n, input int a, input int b);
        k_len   = 8'(k);
        n_tiles = 8'(n);
        a_base  = 8'(a);
        b_base  = 8'(b);
        start   = 1'b1;
        cmd0    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Move to the negedge of command-relative cycle rel (rel must increase).
    task automatic atCycle(input int rel);
        while (cyc < cmd0 + rel) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    // Wait for ready with a cycle budget; optionally pulse ignored starts.
    task automatic waitIdle(input int budget, input bit noise);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                seen = 1;
            end else if (noise && $urandom_range(0, 5) == 0) begin
                k_len   = 8'($urandom_range(1, 5));
                n_tiles = 8'($urandom_range(1, 4));
                a_base  = 8'($urandom_range(0, 255));
                b_base  = 8'($urandom_range(0, 255));
                start   = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        if (!seen) begin
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL wait_ready: ready still 0 after %0d cycles, required 1", budget);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        k_len = '0; n_tiles = '0; a_base = '0; b_base = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_ready", 32'(ready), 32'd1);
        checkOutput("reset_done", 32'(done), 32'd0);

        $display("[TB] scenario: k_len=3 n_tiles=1");
        applyStimulus(3, 1, 'h10, 'h20);
        atCycle(1);  checkOutput("s1_addr_c1", 32'(a_rd_addr), 32'h10);
        atCycle(2);  checkOutput("s1_addr_c2", 32'(a_rd_addr), 32'h11);
                     checkOutput("s1_fin0_c2", 32'(finish_diag[0]), 32'd1);
        atCycle(3);  checkOutput("s1_addr_c3", 32'(a_rd_addr), 32'h12);
        atCycle(5);  checkOutput("s1_fin0_c5", 32'(finish_diag[0]), 32'd1);
                     checkOutput("s1_fz_c5", 32'(feed_zero), 32'd1);
        atCycle(6);  checkOutput("s1_rv0_c6", 32'(result_valid_diag[0]), 32'd1);
        atCycle(12); checkOutput("s1_rv6_c12", 32'(result_valid_diag[6]), 32'd1);
        atCycle(13); checkOutput("s1_done_c13", 32'(done), 32'd1);
        waitIdle(100, 0);

        $display("[TB] scenario: k_len=2 n_tiles=2");
        applyStimulus(2, 2, 'h40, 'h80);
        atCycle(2);  checkOutput("s2_fin0_c2", 32'(finish_diag[0]), 32'd1);
        atCycle(3);  checkOutput("s2_fin0_c3", 32'(finish_diag[0]), 32'd0);
                     checkOutput("s2_rv0_c3", 32'(result_valid_diag[0]), 32'd0);
        atCycle(4);  checkOutput("s2_fin0_c4", 32'(finish_diag[0]), 32'd1);
        atCycle(5);  checkOutput("s2_rv0_c5", 32'(result_valid_diag[0]), 32'd1);
        atCycle(6);  checkOutput("s2_fin0_c6", 32'(finish_diag[0]), 32'd1);
                     checkOutput("s2_rv0_c6", 32'(result_valid_diag[0]), 32'd0);
        atCycle(7);  checkOutput("s2_rv0_c7", 32'(result_valid_diag[0]), 32'd1);
        atCycle(13); checkOutput("s2_done_c13", 32'(done), 32'd0);
        atCycle(14); checkOutput("s2_done_c14", 32'(done), 32'd1);
        waitIdle(100, 0);

        $display("[TB] scenario: k_len=1 n_tiles=3");
        applyStimulus(1, 3, 'h00, 'h00);
        atCycle(4);  checkOutput("s3_fin3_c4", 32'(finish_diag[3]), 32'd0);
        for (int c = 5; c <= 8; c++) begin
            atCycle(c);
            checkOutput("s3_fin3", 32'(finish_diag[3]), 32'd1);
            if (c == 5) checkOutput("s3_fin0_c5", 32'(finish_diag[0]), 32'd1);
        end
        waitIdle(100, 0);

        $display("[TB] scenario: address wrap");
        applyStimulus(4, 1, 'hFE, 'h7F);
        atCycle(1);  checkOutput("s4_addr_c1", 32'(a_rd_addr), 32'hFE);
        atCycle(2);  checkOutput("s4_addr_c2", 32'(a_rd_addr), 32'hFF);
        atCycle(3);  checkOutput("s4_addr_c3", 32'(a_rd_addr), 32'h00);
        atCycle(4);  checkOutput("s4_addr_c4", 32'(a_rd_addr), 32'h01);
        waitIdle(100, 0);

        $display("[TB] scenario: k_len=0 then ignored start");
        applyStimulus(0, 4, 'h11, 'h22);
        atCycle(1);  checkOutput("s5_done_c1", 32'(done), 32'd1);
                     checkOutput("s5_ready_c1", 32'(ready), 32'd1);
                     checkOutput("s5_rd_c1", 32'(a_rd_en), 32'd0);
        applyStimulus(2, 1, 'h50, 'h60);
        atCycle(2);
        @(posedge clk); #1;
        k_len = 8'd5; n_tiles = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        atCycle(11); checkOutput("s5_done_c11", 32'(done), 32'd0);
        atCycle(12); checkOutput("s5_done_c12", 32'(done), 32'd1);
        waitIdle(100, 0);

        $display("[TB] scenario: reset mid-stream");
        applyStimulus(8, 1, 'h33, 'h44);
        while (cyc < cmd0 + 3) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("s6_ready", 32'(ready), 32'd1);
        checkOutput("s6_rd_en", 32'(a_rd_en), 32'd0);
        checkOutput("s6_addr", 32'(a_rd_addr), 32'd0);
        checkOutput("s6_fin", 32'(finish_diag), 32'd0);
        checkOutput("s6_done", 32'(done), 32'd0);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(3, 1, 'h00, 'h00);
        atCycle(1);  checkOutput("s6_addr_c1", 32'(a_rd_addr), 32'h00);
        atCycle(3);  checkOutput("s6_addr_c3", 32'(a_rd_addr), 32'h02);
        atCycle(5);  checkOutput("s6_fin0_c5", 32'(finish_diag[0]), 32'd1);
        atCycle(13); checkOutput("s6_done_c13", 32'(done), 32'd1);
        waitIdle(100, 0);

        $display("[TB] scenario: randomized commands");
        for (int r = 0; r < 40; r++) begin
            applyStimulus($urandom_range(0, 5), $urandom_range(0, 4),
                          $urandom_range(0, 255), $urandom_range(0, 255));
            waitIdle(200, 1);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        waitIdle(200, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
